// File: rtl/resize_sequencer_if.sv
// Pixel source, pixel sink and resizeFilter connections of resize_sequencer.
//   in_*      : valid/ready pixel source (sequencer is the consumer)
//   out_*     : valid-only pixel sink (sink accepts every beat)
//   flt_*     : resizeFilter control, config and data
// master modport is the sequencer side; slave is the environment/filter side.
interface resize_sequencer_if;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        in_ready;
  logic        flt_enable;
  logic        flt_enable_process;
  logic [7:0]  flt_image_input;
  logic [31:0] flt_width;
  logic [31:0] flt_depth;
  logic [31:0] flt_resize_size;
  logic        flt_enlargen;
  logic        flt_finish;
  logic [7:0]  flt_image_output;
  logic [7:0]  out_pixel;
  logic        out_valid;

  modport master (
    input  in_pixel, in_valid, flt_finish, flt_image_output,
    output in_ready, flt_enable, flt_enable_process, flt_image_input,
           flt_width, flt_depth, flt_resize_size, flt_enlargen,
           out_pixel, out_valid
  );

  modport slave (
    output in_pixel, in_valid, flt_finish, flt_image_output,
    input  in_ready, flt_enable, flt_enable_process, flt_image_input,
           flt_width, flt_depth, flt_resize_size, flt_enlargen,
           out_pixel, out_valid
  );
endinterface

// File: rtl/resize_sequencer.sv
// resize_sequencer: runs one resizeFilter job (load -> process -> drain).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        job launch (IDLE only) / synchronous cancel
//   cfg_*               job configuration, latched on start
//   bus                 pixel source/sink and filter connections (master)
//   busy, done, err     status; done/err are one-cycle pulses
// The output pixel count N is computed in CALC with a subtract-loop divider
// and a shift-add multiplier; the final product register holds N for DRAIN.
module resize_sequencer #(
  parameter int unsigned MAX_IMG_WIDTH  = 500,
  parameter int unsigned MAX_IMG_HEIGHT = 500,
  parameter int unsigned MAX_SCALE      = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          cfg_width,
  input  logic [15:0]          cfg_height,
  input  logic [3:0]           cfg_scale,
  input  logic                 cfg_enlarge,
  resize_sequencer_if.master   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_CALC, S_LOAD, S_LTAIL, S_PROC,
    S_PWAIT, S_PTAIL, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t state, nxt;

  logic [15:0]     w_q, h_q;
  logic [3:0]      s_q;
  logic            enl_q;
  logic [7:0]      img_in_q;
  logic [1:0]      calc_ph;   // 0: width term, 1: height term, 2: product
  logic [15:0]     rem, quo;
  logic [31:0]     mcand, mplier, acc, a_q;
  logic [31:0]     beat_cnt;
  logic [WD_W-1:0] wd;

  logic        cfg_bad, dim_done, calc_done, timeout, last_beat;
  logic [31:0] dim_res;

  assign cfg_bad = (s_q == 4'd0) || (32'(s_q) > MAX_SCALE) ||
                   (w_q == 16'd0) || (32'(w_q) > MAX_IMG_WIDTH) ||
                   (h_q == 16'd0) || (32'(h_q) > MAX_IMG_HEIGHT) ||
                   (!enl_q && ((w_q < 16'(s_q)) || (h_q < 16'(s_q))));

  // Per-dimension term: floor(D/S) when shrinking, D*S when enlarging.
  assign dim_done  = enl_q ? (mplier == 32'd0) : (rem < 16'(s_q));
  assign dim_res   = enl_q ? acc : {16'd0, quo};
  assign calc_done = (calc_ph == 2'd2) && (mplier == 32'd0);
  assign timeout   = (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign last_beat = (beat_cnt == acc - 32'd1);   // acc holds N after CALC

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt                    = state;
    bus.in_ready           = 1'b0;
    bus.flt_enable         = 1'b0;
    bus.flt_enable_process = 1'b0;
    bus.out_valid          = 1'b0;
    bus.out_pixel          = 8'd0;
    busy                   = (state != S_IDLE);
    done                   = 1'b0;
    err                    = 1'b0;
    unique case (state)
      S_IDLE:  if (start) nxt = S_CHECK;
      S_CHECK: nxt = cfg_bad ? S_ERR : S_CALC;
      S_CALC:  if (calc_done) nxt = S_LOAD;
      S_LOAD: begin
        bus.in_ready   = 1'b1;
        bus.flt_enable = 1'b1;
        // finish in the same cycle as a missing pixel is not an underrun
        if (timeout)             nxt = S_ERR;
        else if (bus.flt_finish) nxt = S_LTAIL;
        else if (!bus.in_valid)  nxt = S_ERR;
      end
      S_LTAIL: begin
        bus.flt_enable = 1'b1;
        nxt = timeout ? S_ERR : S_PROC;
      end
      S_PROC: begin
        bus.flt_enable_process = 1'b1;
        nxt = timeout ? S_ERR : S_PWAIT;
      end
      S_PWAIT: begin
        bus.flt_enable_process = 1'b1;
        if (timeout)             nxt = S_ERR;
        else if (bus.flt_finish) nxt = S_PTAIL;
      end
      S_PTAIL: begin
        bus.flt_enable_process = 1'b1;
        nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_pixel = bus.flt_image_output;
        if (last_beat) nxt = S_DONE;
      end
      S_DONE: begin done = 1'b1; nxt = S_IDLE; end
      S_ERR:  begin err  = 1'b1; nxt = S_IDLE; end
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0; h_q <= '0; s_q <= '0; enl_q <= 1'b0;
      img_in_q <= '0; calc_ph <= '0; rem <= '0; quo <= '0;
      mcand <= '0; mplier <= '0; acc <= '0; a_q <= '0;
      beat_cnt <= '0; wd <= '0;
    end else begin
      if (state == S_IDLE && start && !abort) begin
        w_q <= cfg_width; h_q <= cfg_height; s_q <= cfg_scale; enl_q <= cfg_enlarge;
      end
      if (state == S_LOAD) img_in_q <= bus.in_pixel;

      if ((nxt == S_LOAD && state != S_LOAD) || (nxt == S_PWAIT && state != S_PWAIT))
        wd <= '0;
      else if (state inside {S_LOAD, S_LTAIL, S_PROC, S_PWAIT})
        wd <= wd + 1'b1;

      if (state == S_PTAIL)      beat_cnt <= '0;
      else if (state == S_DRAIN) beat_cnt <= beat_cnt + 32'd1;

      if (state == S_CHECK) begin
        calc_ph <= 2'd0; rem <= w_q; quo <= '0;
        mcand <= {16'd0, w_q}; mplier <= {28'd0, s_q}; acc <= '0;
      end else if (state == S_CALC) begin
        if (calc_ph != 2'd2 && dim_done) begin
          if (calc_ph == 2'd0) begin
            a_q <= dim_res; rem <= h_q; quo <= '0;
            mcand <= {16'd0, h_q}; mplier <= {28'd0, s_q}; acc <= '0;
            calc_ph <= 2'd1;
          end else begin
            mcand <= a_q; mplier <= dim_res; acc <= '0;
            calc_ph <= 2'd2;
          end
        end else if (calc_ph == 2'd2 || enl_q) begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          rem <= rem - 16'(s_q);
          quo <= quo + 16'd1;
        end
      end
    end
  end

  assign bus.flt_image_input = img_in_q;
  assign bus.flt_width       = {16'd0, w_q};
  assign bus.flt_depth       = {16'd0, h_q};
  assign bus.flt_resize_size = {28'd0, s_q};
  assign bus.flt_enlargen    = enl_q;
endmodule

// File: tb/tb_resize_sequencer.sv
module tb_resize_sequencer;
  localparam int TMO    = 50;
  localparam int BUDGET = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_width = '0;
  logic [15:0] cfg_height = '0;
  logic [3:0]  cfg_scale = '0;
  logic        cfg_enlarge = 1'b0;
  logic        busy, done, err;
  int          checks = 0;
  int          fails = 0;

  resize_sequencer_if bus();

  resize_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_scale(cfg_scale),
    .cfg_enlarge(cfg_enlarge), .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, {24'd0, busy, done, err, bus.in_ready, bus.flt_enable,
        bus.flt_enable_process, bus.out_valid, bus.flt_enlargen}, 32'd0);
    chk({tag, "_data"}, {16'd0, bus.out_pixel, bus.flt_image_input}, 32'd0);
    chk({tag, "_cfg"}, bus.flt_width | bus.flt_depth | bus.flt_resize_size, 32'd0);
  endtask

  // One job: filter model finishes LOAD after load_len pixels and PWAIT after
  // pwait_len cycles (it also raises finish in the PROC cycle, which must be
  // ignored). Expected outcome comes from the job rules with plain arithmetic.
  task automatic run_job(input int w, input int h, input int s, input bit enl,
                         input int load_len, input int pwait_len, input int underrun_at,
                         input int abort_at, input int rst_beat, input bit hang);
    bit   bad, under, saw_en = 0, gap = 0, prev_ready = 0, aborted = 0, resetted = 0;
    int   n_exp, loadcnt = 0, pc = 0, beats = 0, last_c = -1, done_c = -1, err_c = -1;
    int   done_n = 0, err_n = 0;
    logic [7:0] prev_pix = '0;
    bad   = (s == 0) || (s > 10) || (w == 0) || (w > 500) || (h == 0) || (h > 500) ||
            (!enl && (w < s || h < s));
    under = !bad && underrun_at != 0 && underrun_at < load_len;
    n_exp = bad ? 0 : (enl ? (w * s) * (h * s) : (w / s) * (h / s));

    @(negedge clk);
    cfg_width = 16'(w); cfg_height = 16'(h); cfg_scale = 4'(s); cfg_enlarge = enl;
    start = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk("busy", {31'd0, busy}, 32'd1);
        chk("flt_width", bus.flt_width, 32'(w));
        chk("flt_depth", bus.flt_depth, 32'(h));
        chk("flt_scale", bus.flt_resize_size, 32'(s & 15));
        chk("flt_enl", {31'd0, bus.flt_enlargen}, {31'd0, enl});
      end
      if (bus.flt_enable) saw_en = 1;
      if (prev_ready) chk("img_in", {24'd0, bus.flt_image_input}, {24'd0, prev_pix});
      if (bus.out_valid) begin
        beats++; last_c = c;
        chk("out_pixel", {24'd0, bus.out_pixel}, {24'd0, bus.flt_image_output});
      end else if (beats > 0 && beats < n_exp) gap = 1;
      if (done) begin done_n++; done_c = c; end
      if (err)  begin err_n++;  err_c = c;  end
      if (aborted) begin
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_flags", done_n + err_n, 32'd0);
        break;
      end
      if (done || err) break;

      prev_ready = bus.in_ready;
      bus.in_valid = 1'b0; bus.flt_finish = 1'b0;
      if (bus.in_ready) begin
        loadcnt++;
        prev_pix = 8'($urandom);
        bus.in_pixel = prev_pix;
        bus.in_valid = (loadcnt != underrun_at);
        bus.flt_finish = (loadcnt == load_len);
        if (loadcnt == abort_at) begin abort = 1'b1; aborted = 1; end
      end else abort = 1'b0;
      if (bus.flt_enable_process) begin
        pc++;
        bus.flt_finish = !hang && (pc == 1 || pc == pwait_len + 1);
      end
      bus.flt_image_output = 8'($urandom);
      if (rst_beat != 0 && beats == rst_beat) begin
        rst_n = 1'b0;
        #1 chk_zero("async_rst");
        resetted = 1;
        break;
      end
    end
    abort = 1'b0; bus.in_valid = 1'b0; bus.flt_finish = 1'b0;

    if (resetted) begin
      @(negedge clk);
      chk_zero("held_rst");
      rst_n = 1'b1;
    end else if (aborted) begin
      chk("abort_no_drain", beats, 32'd0);
    end else if (done_n + err_n == 0) begin
      chk("job_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      chk("idle_after", {31'd0, busy}, 32'd0);
      chk("en_after", {31'd0, bus.flt_enable}, 32'd0);
      if (bad) begin
        chk("bad_err", err_n, 32'd1);
        chk("bad_err_cycle", err_c, 32'd2);
        chk("bad_no_done", done_n, 32'd0);
        chk("bad_no_enable", {31'd0, saw_en}, 32'd0);
      end else if (under) begin
        chk("under_err", err_n, 32'd1);
        chk("under_no_done", done_n, 32'd0);
        chk("under_at", loadcnt, 32'(underrun_at));
        chk("under_beats", beats, 32'd0);
      end else if (hang) begin
        chk("tmo_err", err_n, 32'd1);
        chk("tmo_proc_cycles", pc, 32'(TMO + 1));
        chk("tmo_no_done", done_n, 32'd0);
      end else begin
        chk("done_n", done_n, 32'd1);
        chk("no_err", err_n, 32'd0);
        chk("beats", beats, 32'(n_exp));
        chk("no_gap", {31'd0, gap}, 32'd0);
        chk("done_after_last", done_c, 32'(last_c + 1));
        chk("proc_cycles", pc, 32'(pwait_len + 2));
      end
    end
  endtask

  initial begin
    bus.in_pixel = '0; bus.in_valid = 1'b0; bus.flt_finish = 1'b0; bus.flt_image_output = '0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_job(6, 3, 3, 0, 18, 3, 0, 0, 0, 0);        // shrink, N=2
    run_job(2, 2, 2, 1, 4, 2, 0, 0, 0, 0);         // enlarge, N=16
    run_job(6, 3, 0, 0, 18, 3, 0, 0, 0, 0);        // scale 0
    run_job(6, 3, 11, 0, 18, 3, 0, 0, 0, 0);       // scale above max
    run_job(2, 4, 3, 0, 18, 3, 0, 0, 0, 0);        // shrink width < scale
    run_job(501, 20, 2, 0, 18, 3, 0, 0, 0, 0);     // width above max
    run_job(6, 6, 2, 0, 10, 2, 5, 0, 0, 0);        // underrun on 5th LOAD cycle
    run_job(4, 4, 2, 0, 6, 2, 6, 0, 0, 0);         // finish and missing pixel together
    run_job(4, 4, 2, 0, 5, 1, 0, 0, 0, 1);         // PWAIT watchdog
    run_job(2, 2, 2, 1, 4, 2, 0, 0, 7, 0);         // reset mid-DRAIN
    run_job(6, 3, 3, 0, 18, 3, 0, 4, 0, 0);        // abort mid-LOAD
    run_job(6, 3, 3, 0, 18, 3, 0, 0, 0, 0);        // clean rerun
    run_job(500, 10, 10, 0, 8, 1, 0, 0, 0, 0);     // max width shrink, N=50
    run_job(500, 1, 1, 1, 3, 1, 0, 0, 0, 0);       // max width enlarge, N=500

    for (int i = 0; i < 12; i++) begin
      int w, h, s, ll, pw, ua;
      bit enl;
      enl = 1'($urandom_range(0, 1));
      if (enl) begin
        w = $urandom_range(1, 8); h = $urandom_range(1, 8); s = $urandom_range(0, 4);
      end else begin
        w = $urandom_range(1, 40); h = $urandom_range(1, 40); s = $urandom_range(0, 11);
      end
      ll = $urandom_range(1, 20);
      pw = $urandom_range(1, 6);
      ua = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ll)) : 0;
      run_job(w, h, s, enl, ll, pw, ua, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
